// File: rtl/skid_buffer_pkg.sv
// Shared types for the skid_buffer register slice: FSM state encoding and entry count.
package skid_buffer_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

  localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/skid_buffer_sat_counter.sv
// sat_counter: counts cycles with inc high, sticking at all-ones; cleared by async reset.
// Latency: count reflects inc one cycle later; no backpressure interaction.
module sat_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (inc && (count != {CNT_WIDTH{1'b1}})) begin
      count <= count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/skid_buffer.sv
// 2-entry valid/ready slice, 1-cycle forward latency; in_ready decoded from the state flop only.
// Full throughput under backpressure via skid entry; SKID_BUFFER_STALL_CNT_EN adds stall_cnt.
module skid_buffer
  import skid_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data
`ifdef SKID_BUFFER_STALL_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]  stall_cnt
`endif
);

  skid_state_e           state;
  logic [DATA_WIDTH-1:0] main_q;
  logic [DATA_WIDTH-1:0] skid_q;
  logic                  acc;
  logic                  con;

  // Both handshakes derive from the state register, so out_ready never reaches in_ready.
  assign out_valid = (state != EMPTY);
  assign in_ready  = (state != FULL);
  assign out_data  = main_q;

  assign acc = in_valid && in_ready;
  assign con = out_valid && out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (acc) begin
            state  <= BUSY;
            main_q <= in_data;
          end
        end
        BUSY: begin
          if (acc && !con) begin
            state  <= FULL;
            skid_q <= in_data;
          end else if (!acc && con) begin
            state <= EMPTY;
          end else if (acc && con) begin
            main_q <= in_data;
          end
        end
        FULL: begin
          if (con) begin
            state  <= BUSY;
            main_q <= skid_q;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

`ifdef SKID_BUFFER_STALL_CNT_EN
  sat_counter #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_stall_cnt (
    .clk    (clk),
    .reset_n(reset_n),
    .inc    (out_valid && !out_ready),
    .count  (stall_cnt)
  );
`else
  logic unused_cnt_width;
  assign unused_cnt_width = ^CNT_WIDTH;
`endif

endmodule

// File: tb/tb_skid_buffer.sv
// Bench for skid_buffer: directed vector table, streaming, random traffic against a queue model.
module tb_skid_buffer;
  import skid_buffer_pkg::*;

  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
`ifdef SKID_BUFFER_STALL_CNT_EN
  logic [CW-1:0] stall_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  skid_buffer #(
    .DATA_WIDTH(DW),
    .CNT_WIDTH (CW)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
`ifdef SKID_BUFFER_STALL_CNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic          rst_n;
    logic          iv;
    logic [DW-1:0] d;
    logic          ordy;
    logic          e_ov;
    logic          e_ir;
    logic [DW-1:0] e_od;
  } vec_t;

  vec_t vecs[13];

  initial begin
    // backpressure: 0x11, 0x22 fill both entries, 0x33 ignored while full
    vecs[0]  = '{1'b1, 1'b1, 32'h11, 1'b0, 1'b1, 1'b1, 32'h11};
    vecs[1]  = '{1'b1, 1'b1, 32'h22, 1'b0, 1'b1, 1'b0, 32'h11};
    vecs[2]  = '{1'b1, 1'b1, 32'h33, 1'b0, 1'b1, 1'b0, 32'h11};
    vecs[3]  = '{1'b1, 1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 32'h22};
    vecs[4]  = '{1'b1, 1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 32'h22};
    // simultaneous accept and consume while holding one beat
    vecs[5]  = '{1'b1, 1'b1, 32'h5,  1'b0, 1'b1, 1'b1, 32'h5};
    vecs[6]  = '{1'b1, 1'b1, 32'h6,  1'b1, 1'b1, 1'b1, 32'h6};
    vecs[7]  = '{1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 32'h6};
    vecs[8]  = '{1'b1, 1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 32'h6};
    // fill with 0xA/0xB, then reset discards both
    vecs[9]  = '{1'b1, 1'b1, 32'hA,  1'b0, 1'b1, 1'b1, 32'hA};
    vecs[10] = '{1'b1, 1'b1, 32'hB,  1'b0, 1'b1, 1'b0, 32'hA};
    vecs[11] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 32'h0};
    vecs[12] = '{1'b1, 1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 32'h0};
  end

  task automatic do_reset();
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    logic [DW-1:0] q[$];
    logic [DW-1:0] sent_d;
    logic          hold;
    logic          acc;
    logic          con;
    logic          ir_a;
    int            sent;
    int            got_beats;
    int            cycles;

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #1;
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_in_ready", in_ready, 1'b1);
    check("reset_out_data", out_data, 0);
    step();
    step();
    reset_n = 1'b1;

    // directed vector table
    for (int i = 0; i < 13; i++) begin
      reset_n   = vecs[i].rst_n;
      in_valid  = vecs[i].iv;
      in_data   = vecs[i].d;
      out_ready = vecs[i].ordy;
      if (!vecs[i].rst_n) begin
        #1;
        check($sformatf("vec%0d_async_ov", i), out_valid, 1'b0);
        check($sformatf("vec%0d_async_ir", i), in_ready, 1'b1);
        check($sformatf("vec%0d_async_od", i), out_data, 0);
      end
      step();
      check($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].e_ov);
      check($sformatf("vec%0d_in_ready", i), in_ready, vecs[i].e_ir);
      check($sformatf("vec%0d_out_data", i), out_data, vecs[i].e_od);
    end

    // streaming: one beat per cycle, one cycle latency
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_data = DW'(i);
      check("stream_in_ready", in_ready, 1'b1);
      step();
      check("stream_out_valid", out_valid, 1'b1);
      check("stream_out_data", out_data, i);
    end
    in_valid = 1'b0;
    step();
    check("stream_drained", out_valid, 1'b0);

    // random traffic against a bounded FIFO model
    q.delete();
    sent      = 0;
    got_beats = 0;
    cycles    = 0;
    hold      = 1'b0;
    sent_d    = '0;
    while (got_beats < 10000 && cycles < 60000) begin
      check("rand_out_valid", out_valid, q.size() > 0);
      check("rand_in_ready", in_ready, q.size() < SKID_DEPTH);
      if (q.size() > 0) check("rand_out_data", out_data, q[0]);

      if (!hold) begin
        in_valid = ($urandom_range(0, 99) < 50) && (sent < 10000);
        sent_d   = $urandom();
      end
      in_data = sent_d;
      // wiggle out_ready inside the cycle: in_ready must not follow it
      out_ready = 1'b0;
      #1;
      ir_a = in_ready;
      out_ready = 1'b1;
      #1;
      check("rand_no_comb_path", in_ready, ir_a);
      out_ready = ($urandom_range(0, 99) < 30);

      acc = in_valid && (q.size() < SKID_DEPTH);
      con = (q.size() > 0) && out_ready;
      hold = in_valid && !acc;
      if (con) begin
        void'(q.pop_front());
        got_beats++;
      end
      if (acc) begin
        q.push_back(in_data);
        sent++;
      end
      step();
      cycles++;
    end
    check("rand_beats_delivered", got_beats, 10000);
    check("rand_model_empty", q.size(), 0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    check("rand_final_empty", out_valid, 1'b0);

`ifdef SKID_BUFFER_STALL_CNT_EN
    do_reset();
    check("stall_after_reset", stall_cnt, 0);
    in_valid  = 1'b1;
    in_data   = 32'h77;
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    check("stall_first", stall_cnt, 0);
    for (int k = 1; k <= 20; k++) begin
      step();
      check($sformatf("stall_k%0d", k), stall_cnt, (k > 15) ? 15 : k);
      check("stall_data_held", out_data, 32'h77);
    end
    reset_n = 1'b0;
    #1;
    check("stall_cleared", stall_cnt, 0);
    step();
    reset_n = 1'b1;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
